// File: rtl/enc_input_buffer_pkg.sv
// Shared encoder constants and types for the RS encoder input buffer.
//
// Contents:
//   ENC_SYM, RSC_SYM_WID      word geometry (symbols per word, bits per symbol)
//   ENC_IBF_DEP, ENC_IBF_PRI  FIFO depth (power of two, >= 2) and priming fill level
//   ENC_DATA_W                word width in bits
//   IBF_PTR_W, IBF_LVL_W      pointer and level widths
//   ibf_phase_e               buffer state: idle, priming, running
package enc_input_buffer_pkg;

  localparam int RSC_SYM_WID = 8;
  localparam int ENC_SYM     = 16;
  localparam int ENC_IBF_DEP = 8;
  localparam int ENC_IBF_PRI = 4;

  localparam int ENC_DATA_W = ENC_SYM * RSC_SYM_WID;
  localparam int IBF_PTR_W  = $clog2(ENC_IBF_DEP);
  localparam int IBF_LVL_W  = $clog2(ENC_IBF_DEP + 1);

  typedef enum logic [1:0] {
    IBF_IDL = 2'd0,
    IBF_PRI = 2'd1,
    IBF_RUN = 2'd2
  } ibf_phase_e;

endpackage

// File: rtl/enc_ibf_mem.sv
// Word storage for the encoder input buffer.
//
// Simple dual-port array, ENC_IBF_DEP words of ENC_DATA_W bits:
//   clk      in   write clock
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   raddr_i  in   read address (asynchronous read)
//   rdata_o  out  word at raddr_i
// The contents are deliberately not reset.
module enc_ibf_mem
  import enc_input_buffer_pkg::*;
(
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [IBF_PTR_W-1:0]  waddr_i,
  input  logic [ENC_DATA_W-1:0] wdata_i,
  input  logic [IBF_PTR_W-1:0]  raddr_i,
  output logic [ENC_DATA_W-1:0] rdata_o
);

  logic [ENC_DATA_W-1:0] mem_q [ENC_IBF_DEP];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/enc_input_buffer.sv
// Input buffer in front of the RS encoder core.
//
// Accepts message words over a valid/ready stream, holds them in a circular
// FIFO and presents the head word (show-ahead) to the encoder core, which
// pops on every cycle it is not stalled once the buffer has been primed.
//
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   in_data       message word, symbol 0 in the LSBs
//   in_valid      in_data valid
//   in_ready      buffer can accept a word this cycle
//   flush         drop stored data and return to idle
//   con_stall     core does not consume this cycle
//   enc_data      head word, zero when nothing valid is presented
//   enc_valid     enc_data holds real data
//   ibf_phase     current state (idle / priming / running)
//   ibf_level     stored word count
//   err_underrun  sticky flag: core popped while empty
//   err_clear     clears err_underrun
//
// Handshake: a word transfers on a cycle where in_valid and in_ready are both
// high. in_ready depends only on registered state and flush, never on
// in_valid, and a pop does not free a slot for a push in the same cycle.
module enc_input_buffer
  import enc_input_buffer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ENC_DATA_W-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  input  logic                  con_stall,
  output logic [ENC_DATA_W-1:0] enc_data,
  output logic                  enc_valid,
  output ibf_phase_e            ibf_phase,
  output logic [IBF_LVL_W-1:0]  ibf_level,
  output logic                  err_underrun,
  input  logic                  err_clear
);

  localparam logic [IBF_LVL_W-1:0] DEP_L = IBF_LVL_W'(ENC_IBF_DEP);
  localparam logic [IBF_LVL_W-1:0] PRI_L = IBF_LVL_W'(ENC_IBF_PRI);
  localparam logic [IBF_LVL_W-1:0] ONE_L = IBF_LVL_W'(1);
  localparam logic [IBF_PTR_W-1:0] PONE  = IBF_PTR_W'(1);

  ibf_phase_e             phase_q;
  logic [IBF_PTR_W-1:0]   wr_ptr_q;
  logic [IBF_PTR_W-1:0]   rd_ptr_q;
  logic [IBF_LVL_W-1:0]   level_q;
  logic [IBF_LVL_W-1:0]   level_d;
  logic                   err_q;

  logic                   push;
  logic                   pop_req;
  logic                   pop;
  logic                   underrun;
  logic                   not_empty;
  logic [ENC_DATA_W-1:0]  head_word;

  assign not_empty = (level_q != '0);
  assign in_ready  = (level_q < DEP_L) & ~flush;
  assign push      = in_valid & in_ready;
  assign pop_req   = (phase_q == IBF_RUN) & ~con_stall;
  assign pop       = pop_req & not_empty;
  // An empty pop hands the core a zero word; pointers and level stay put.
  assign underrun  = pop_req & ~not_empty;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + ONE_L;
      2'b01:   level_d = level_q - ONE_L;
      default: level_d = level_q;
    endcase
  end

  // Single state process: flush overrides every update except the error flag,
  // which only reset or err_clear can lower.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q  <= IBF_IDL;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      err_q    <= 1'b0;
    end else if (flush) begin
      phase_q  <= IBF_IDL;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      level_q <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + PONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PONE;

      // Setting wins over clearing so an underrun is never lost.
      if (underrun)       err_q <= 1'b1;
      else if (err_clear) err_q <= 1'b0;

      case (phase_q)
        IBF_IDL: begin
          if (push) phase_q <= (level_d >= PRI_L) ? IBF_RUN : IBF_PRI;
        end
        IBF_PRI: begin
          if (level_d >= PRI_L) phase_q <= IBF_RUN;
        end
        IBF_RUN: begin
          // Left only through flush or reset, keeping codeword alignment.
          phase_q <= IBF_RUN;
        end
        default: phase_q <= IBF_IDL;
      endcase
    end
  end

  enc_ibf_mem u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_word)
  );

  assign enc_valid    = (phase_q == IBF_RUN) & not_empty;
  assign enc_data     = enc_valid ? head_word : '0;
  assign ibf_phase    = phase_q;
  assign ibf_level    = level_q;
  assign err_underrun = err_q;

endmodule

// File: tb/tb_enc_input_buffer.sv
// Directed bench for enc_input_buffer: priming, stall hold, full/wrap,
// underrun stickiness, flush and synchronous reset behaviour.
module tb_enc_input_buffer;
  import enc_input_buffer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n;
  logic [ENC_DATA_W-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  flush;
  logic                  con_stall;
  logic [ENC_DATA_W-1:0] enc_data;
  logic                  enc_valid;
  ibf_phase_e            ibf_phase;
  logic [IBF_LVL_W-1:0]  ibf_level;
  logic                  err_underrun;
  logic                  err_clear;

  enc_input_buffer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .flush        (flush),
    .con_stall    (con_stall),
    .enc_data     (enc_data),
    .enc_valid    (enc_valid),
    .ibf_phase    (ibf_phase),
    .ibf_level    (ibf_level),
    .err_underrun (err_underrun),
    .err_clear    (err_clear)
  );

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_pass = 0;
  logic [ENC_DATA_W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [ENC_DATA_W-1:0] obs,
                     input logic [ENC_DATA_W-1:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ENC_DATA_W-1:0] w(input int k);
    logic [7:0] b;
    b = k[7:0];
    return {ENC_SYM{b}};
  endfunction

  // ---------------- driver tasks ----------------
  // Advance to just after the next rising edge; inputs change only here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    err_clear = 1'b0;
  endtask

  task automatic push_word(input int k);
    in_valid = 1'b1;
    in_data  = w(k);
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_phase"}, ENC_DATA_W'(ibf_phase), ENC_DATA_W'(IBF_IDL));
    chk({tag, "_level"}, ENC_DATA_W'(ibf_level), '0);
    chk({tag, "_ready"}, ENC_DATA_W'(in_ready), 1);
    chk({tag, "_valid"}, ENC_DATA_W'(enc_valid), 0);
    chk({tag, "_data"},  enc_data, '0);
    chk({tag, "_err"},   ENC_DATA_W'(err_underrun), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    con_stall = 1'b1;
    idle_inputs();
    cyc();
    cyc();
    rst_n = 1'b1;
    #1;
    chk_reset_state("rst");

    // Prime: four pushes, IDL -> PRI -> RUN on the fourth.
    con_stall = 1'b0;
    push_word(1);
    #1;
    chk("pri1_phase", ENC_DATA_W'(ibf_phase), ENC_DATA_W'(IBF_PRI));
    chk("pri1_valid", ENC_DATA_W'(enc_valid), 0);
    push_word(2);
    push_word(3);
    #1;
    chk("pri3_phase", ENC_DATA_W'(ibf_phase), ENC_DATA_W'(IBF_PRI));
    chk("pri3_level", ENC_DATA_W'(ibf_level), 3);
    push_word(4);
    #1;
    chk("run_phase", ENC_DATA_W'(ibf_phase), ENC_DATA_W'(IBF_RUN));
    chk("run_level", ENC_DATA_W'(ibf_level), 4);
    chk("run_head1", enc_data, w(1));
    chk("run_valid", ENC_DATA_W'(enc_valid), 1);
    cyc();
    chk("run_head2", enc_data, w(2));
    chk("run_level3", ENC_DATA_W'(ibf_level), 3);

    // Stall hold for two cycles at level 3.
    con_stall = 1'b1;
    cyc();
    #1;
    chk("stall1_data", enc_data, w(2));
    chk("stall1_level", ENC_DATA_W'(ibf_level), 3);
    cyc();
    #1;
    chk("stall2_data", enc_data, w(2));
    chk("stall2_level", ENC_DATA_W'(ibf_level), 3);
    con_stall = 1'b0;
    cyc();
    chk("resume_data", enc_data, w(3));
    chk("resume_level", ENC_DATA_W'(ibf_level), 2);

    // Fill to full under stall: W5..W10 occupy slots 4..7 then 0..1.
    con_stall = 1'b1;
    for (int k = 5; k <= 10; k++) push_word(k);
    #1;
    chk("full_level", ENC_DATA_W'(ibf_level), 8);
    chk("full_ready", ENC_DATA_W'(in_ready), 0);
    in_valid = 1'b1;
    in_data  = w(11);
    cyc();
    #1;
    chk("full_ignore_level", ENC_DATA_W'(ibf_level), 8);
    chk("full_head", enc_data, w(3));
    // Pop while full with in_valid still high: W11 must not get in.
    con_stall = 1'b0;
    #1;
    chk("full_pop_ready", ENC_DATA_W'(in_ready), 0);
    cyc();
    in_valid = 1'b0;
    #1;
    chk("after_pop_level", ENC_DATA_W'(ibf_level), 7);
    chk("after_pop_ready", ENC_DATA_W'(in_ready), 1);

    // Drain in order across the 7 -> 0 wrap.
    for (int k = 4; k <= 10; k++) exp_q.push_back(w(k));
    while (exp_q.size() > 0) begin
      chk("drain_data", enc_data, exp_q.pop_front());
      cyc();
    end

    // Underrun: empty with con_stall low.
    #1;
    chk("urun_level", ENC_DATA_W'(ibf_level), 0);
    chk("urun_valid", ENC_DATA_W'(enc_valid), 0);
    chk("urun_data", enc_data, '0);
    chk("urun_phase", ENC_DATA_W'(ibf_phase), ENC_DATA_W'(IBF_RUN));
    chk("urun_err_pre", ENC_DATA_W'(err_underrun), 0);
    cyc();
    chk("urun_err_set", ENC_DATA_W'(err_underrun), 1);
    chk("urun_level_hold", ENC_DATA_W'(ibf_level), 0);
    con_stall = 1'b1;
    cyc();
    chk("urun_err_sticky", ENC_DATA_W'(err_underrun), 1);
    // Set beats clear.
    con_stall = 1'b0;
    err_clear = 1'b1;
    cyc();
    chk("set_beats_clear", ENC_DATA_W'(err_underrun), 1);
    con_stall = 1'b1;
    cyc();
    err_clear = 1'b0;
    #1;
    chk("clear_err", ENC_DATA_W'(err_underrun), 0);

    // Flush at level 5 with a concurrent in_valid.
    for (int k = 21; k <= 25; k++) push_word(k);
    #1;
    chk("pre_flush_level", ENC_DATA_W'(ibf_level), 5);
    chk("pre_flush_head", enc_data, w(21));
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = w(26);
    #1;
    chk("flush_ready", ENC_DATA_W'(in_ready), 0);
    cyc();
    idle_inputs();
    #1;
    chk("flush_phase", ENC_DATA_W'(ibf_phase), ENC_DATA_W'(IBF_IDL));
    chk("flush_level", ENC_DATA_W'(ibf_level), 0);
    chk("flush_ready_after", ENC_DATA_W'(in_ready), 1);
    chk("flush_valid", ENC_DATA_W'(enc_valid), 0);
    chk("flush_err_kept", ENC_DATA_W'(err_underrun), 0);

    // Re-prime: first word out must be W31, not the flushed-cycle W26.
    con_stall = 1'b0;
    for (int k = 31; k <= 34; k++) push_word(k);
    #1;
    chk("reprime_phase", ENC_DATA_W'(ibf_phase), ENC_DATA_W'(IBF_RUN));
    chk("reprime_head", enc_data, w(31));
    for (int k = 0; k < 4; k++) cyc();
    #1;
    chk("redrain_level", ENC_DATA_W'(ibf_level), 0);
    // Empty push while running unstalled: underrun and the word is kept.
    push_word(40);
    #1;
    chk("epush_level", ENC_DATA_W'(ibf_level), 1);
    chk("epush_err", ENC_DATA_W'(err_underrun), 1);
    chk("epush_head", enc_data, w(40));

    // Build level 6 with err set, then check reset behaviour.
    con_stall = 1'b1;
    for (int k = 41; k <= 45; k++) push_word(k);
    #1;
    chk("pre_rst_level", ENC_DATA_W'(ibf_level), 6);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    cyc();
    chk("async_pulse_level", ENC_DATA_W'(ibf_level), 6);
    chk("async_pulse_phase", ENC_DATA_W'(ibf_phase), ENC_DATA_W'(IBF_RUN));
    chk("async_pulse_err", ENC_DATA_W'(err_underrun), 1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
    chk_reset_state("midrst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/enc_input_buffer.md
Name: enc_input_buffer

Overview:
- Upstream stage of the RS encoder datapath. Accepts message words from the user side over a valid/ready stream; one word is ENC_SYM symbols.
- Stores words in a small circular FIFO. Presents one word per cycle to the encoder core, popping on every cycle the encoder controller is not stalled (con_stall low).
- Handles priming before the first codeword, flushing, and sticky underrun detection when the core pops an empty FIFO.

Parameters:
- ENC_SYM, 16, symbols per word (per cycle).
- RSC_SYM_WID, 8, bits per RS symbol.
- ENC_IBF_DEP, 8, FIFO depth in words; must be a power of two, at least 2.
- ENC_IBF_PRI, 4, fill level required to leave priming; 1 <= ENC_IBF_PRI <= ENC_IBF_DEP.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_data  in  ENC_SYM*RSC_SYM_WID  message word; symbol 0 in the LSBs
- in_valid  in  1  in_data valid
- in_ready  out  1  buffer can accept a word this cycle
- flush  in  1  drop stored data and return to idle
- con_stall  in  1  encoder controller stall; high means the core does not consume this cycle
- enc_data  out  ENC_SYM*RSC_SYM_WID  head-of-FIFO word (show-ahead)
- enc_valid  out  1  enc_data holds real data
- ibf_phase  out  IBF_PHASE  current state
- ibf_level  out  $clog2(ENC_IBF_DEP+1)  stored word count
- err_underrun  out  1  sticky underrun flag
- err_clear  in  1  clears err_underrun

Behaviour:
- All state updates on posedge clk. Reset is synchronous: when rst_n is low at the edge, every register returns to its reset value.
- Reset values: ibf_phase=IBF_IDL, ibf_level=0, read and write pointers 0, err_underrun=0.
- Reset consequences: in_ready=1, enc_valid=0, enc_data=0.
- Storage contents are not reset.
- Pointers are $clog2(ENC_IBF_DEP) bits wide and wrap naturally modulo ENC_IBF_DEP. Level is tracked separately, not derived from the pointers.
- push = in_valid & in_ready.
- in_ready = (ibf_level < ENC_IBF_DEP) & ~flush. in_ready is a function of registered state and flush only; it never depends on in_valid. A pop does not free a slot for a push in the same cycle.
- pop_req = (ibf_phase == IBF_RUN) & ~con_stall.
- pop = pop_req & (ibf_level != 0).
- Latency: a word pushed at edge t is readable on enc_data from cycle t+1; there is no fall-through.
- enc_data = mem[rd_ptr] when (ibf_phase == IBF_RUN) & (ibf_level != 0), else all zeros.
- enc_valid = (ibf_phase == IBF_RUN) & (ibf_level != 0).
- Level update: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- Underrun: pop_req with ibf_level == 0.
  - The core receives the zero word; pointers and level do not move.
  - err_underrun is set on the next edge. The state stays in IBF_RUN so the core's codeword alignment is preserved.
- err_underrun priority: set beats err_clear when both happen in the same cycle. Otherwise err_clear drives it to 0.
- State machine (IBF_PHASE):
  - IBF_IDL: level is 0. The first push moves to IBF_PRI, or directly to IBF_RUN if ENC_IBF_PRI == 1.
  - IBF_PRI: no pops. Moves to IBF_RUN on the edge where the next level is >= ENC_IBF_PRI.
  - IBF_RUN: pops per con_stall as above. The state is only left through flush or reset.
- flush: takes precedence over push, pop and all state transitions.
  - Next state is IBF_IDL; pointers and level go to 0.
  - err_underrun is unchanged.
  - in_ready is low during the flush cycle.
- Full: at level == ENC_IBF_DEP, in_ready=0. A simultaneous pop lowers the level, and in_ready rises the next cycle.
- Empty push while in RUN with con_stall=0: counts as an underrun for that cycle. The pushed word is stored and level becomes 1.

Decomposition:
- Shared package encoder.vh:
  - IBF_PHASE enum {IBF_IDL, IBF_PRI, IBF_RUN}, 2-bit.
  - ENC_SYM, RSC_SYM_WID, ENC_IBF_DEP, ENC_IBF_PRI constants alongside the existing RSC_*/ENC_* constants.
- One natural sub-module: enc_ibf_mem.
  - Simple dual-port storage: one write port, one asynchronous read port, ENC_IBF_DEP x ENC_SYM*RSC_SYM_WID, no reset.
  - Pointer, level, state and error logic stay in enc_input_buffer.

Test Plan:
- Reset then prime: push 4 words 0x01..,0x02..,0x03..,0x04.. with con_stall=0.
  - ibf_phase goes IDL -> PRI -> RUN on the edge of the 4th push.
  - enc_data = word1 the next cycle; words come out in order, one per cycle.
- Stall hold: in RUN with level 3, hold con_stall=1 for 2 cycles.
  - enc_data is held at the same word and level stays 3.
  - Pops resume on the first cycle con_stall=0.
- Full: with con_stall=1, push until level=8.
  - in_ready=0; further in_valid is ignored.
  - One pop gives level 7 and in_ready=1 the following cycle; pointer wrap preserves word order across index 7 -> 0.
- Underrun: in RUN, drain to level 0 with con_stall=0.
  - enc_valid=0, enc_data=0, err_underrun=1 next cycle and stays set until err_clear.
  - Set beats clear when both occur together.
- Flush mid-stream: level 5 in RUN, assert flush together with in_valid=1.
  - Next cycle: IDL, level 0, in_ready=1; the word presented on in_data is not stored.
- Reset mid-operation: rst_n=0 for one edge at level 6 with err_underrun=1.
  - All outputs return to their reset values on that edge; an asynchronous rst_n pulse between edges has no effect.
